// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_alloc_pkg;

  localparam int KEY_W          = 7;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_AGE_W      = 8;

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } voice_state_e;

  typedef enum logic {
    S_IDLE       = 1'b0,
    S_STEAL_WAIT = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/voice_allocator_oldest_select.sv
// Picks the lowest-index FREE voice and the oldest non-FREE voice (ties to lowest index).
module oldest_select
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]       free_i,
  input  logic [NUM_VOICES*AGE_W-1:0] age_flat_i,
  output logic [IDX_W-1:0]            free_idx_o,
  output logic                        free_found_o,
  output logic [IDX_W-1:0]            old_idx_o,
  output logic                        old_found_o
);

  logic [AGE_W-1:0] best_age;
  logic [AGE_W-1:0] cur_age;

  always_comb begin
    free_idx_o   = '0;
    free_found_o = 1'b0;
    old_idx_o    = '0;
    old_found_o  = 1'b0;
    best_age     = '0;
    cur_age      = '0;
    // Scanning downwards leaves the lowest FREE index as the final winner.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        free_found_o = 1'b1;
        free_idx_o   = IDX_W'(i);
      end
    end
    // Strict greater-than keeps the lowest index on equal ages.
    for (int i = 0; i < NUM_VOICES; i++) begin
      cur_age = age_flat_i[i*AGE_W +: AGE_W];
      if (!free_i[i] && (!old_found_o || cur_age > best_age)) begin
        old_found_o = 1'b1;
        old_idx_o   = IDX_W'(i);
        best_age    = cur_age;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Key-event to voice allocator with oldest-voice stealing for a bank of envelope generators.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  // Event handshake: an event transfers on a rising edge where ev_valid && ev_ready;
  // ev_ready depends only on registered FSM state, never on ev_valid.
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_is_on,
  input  logic [KEY_W-1:0]            ev_key,
  output logic [NUM_VOICES-1:0]       voice_note_on,
  output logic [NUM_VOICES-1:0]       voice_note_off,
  output logic [KEY_W*NUM_VOICES-1:0] voice_key,
  input  logic [NUM_VOICES-1:0]       voice_busy,
  output logic [NUM_VOICES-1:0]       active_mask,
  output logic                        steal_pulse,
  output fsm_state_e                  dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  fsm_state_e       fsm_q, fsm_d;
  voice_state_e     vstate_q [NUM_VOICES];
  voice_state_e     vstate_d [NUM_VOICES];
  logic [KEY_W-1:0] key_q    [NUM_VOICES];
  logic [KEY_W-1:0] key_d    [NUM_VOICES];
  logic [AGE_W-1:0] age_q    [NUM_VOICES];
  logic [AGE_W-1:0] age_d    [NUM_VOICES];

  logic [KEY_W-1:0]      pend_key_q, pend_key_d;
  logic [IDX_W-1:0]      victim_q, victim_d;
  logic [NUM_VOICES-1:0] note_on_q, note_on_d;
  logic [NUM_VOICES-1:0] note_off_q, note_off_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic                  steal_q, steal_d;

  logic [NUM_VOICES-1:0]       free_mask;
  logic [NUM_VOICES*AGE_W-1:0] age_flat;
  logic [IDX_W-1:0]            free_idx, old_idx, held_idx;
  logic                        free_found, old_found, held_hit;
  logic                        alloc_en;
  logic [IDX_W-1:0]            alloc_idx;
  logic [KEY_W-1:0]            alloc_key;

  always_comb begin
    free_mask = '0;
    age_flat  = '0;
    held_hit  = 1'b0;
    held_idx  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      free_mask[i]                 = (vstate_q[i] == V_FREE);
      age_flat[i*AGE_W +: AGE_W]   = age_q[i];
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vstate_q[i] == V_HELD && key_q[i] == ev_key) begin
        held_hit = 1'b1;
        held_idx = IDX_W'(i);
      end
    end
  end

  oldest_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_select (
    .free_i       (free_mask),
    .age_flat_i   (age_flat),
    .free_idx_o   (free_idx),
    .free_found_o (free_found),
    .old_idx_o    (old_idx),
    .old_found_o  (old_found)
  );

  always_comb begin
    fsm_d      = fsm_q;
    pend_key_d = pend_key_q;
    victim_d   = victim_q;
    note_on_d  = '0;
    note_off_d = '0;
    active_d   = '0;
    steal_d    = 1'b0;
    alloc_en   = 1'b0;
    alloc_idx  = '0;
    alloc_key  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      vstate_d[i] = vstate_q[i];
      key_d[i]    = key_q[i];
      age_d[i]    = age_q[i];
    end

    // Released voices drain once their generator goes idle; the steal victim is handled below.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vstate_q[i] == V_RELEASING && !voice_busy[i] &&
          !(fsm_q == S_STEAL_WAIT && victim_q == IDX_W'(i))) begin
        vstate_d[i] = V_FREE;
      end
    end

    case (fsm_q)
      S_IDLE: begin
        if (ev_valid) begin
          if (ev_is_on) begin
            if (held_hit) begin
              alloc_en = 1'b0;
            end else if (free_found) begin
              alloc_en  = 1'b1;
              alloc_idx = free_idx;
              alloc_key = ev_key;
            end else if (old_found) begin
              victim_d   = old_idx;
              pend_key_d = ev_key;
              fsm_d      = S_STEAL_WAIT;
              if (vstate_q[old_idx] == V_HELD) begin
                note_off_d[old_idx] = 1'b1;
                vstate_d[old_idx]   = V_RELEASING;
              end
            end
          end else if (held_hit) begin
            note_off_d[held_idx] = 1'b1;
            vstate_d[held_idx]   = V_RELEASING;
          end
        end
      end
      S_STEAL_WAIT: begin
        if (!voice_busy[victim_q]) begin
          alloc_en  = 1'b1;
          alloc_idx = victim_q;
          alloc_key = pend_key_q;
          steal_d   = 1'b1;
          fsm_d     = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    if (alloc_en) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == alloc_idx) begin
          vstate_d[i]  = V_HELD;
          key_d[i]     = alloc_key;
          age_d[i]     = '0;
          note_on_d[i] = 1'b1;
        end else if (vstate_q[i] != V_FREE && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      active_d[i] = (vstate_d[i] == V_HELD);
    end
  end

  // Reset parks every voice in RELEASING so a still-busy generator is never retriggered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      pend_key_q <= '0;
      victim_q   <= '0;
      note_on_q  <= '0;
      note_off_q <= '0;
      active_q   <= '0;
      steal_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_q[i] <= V_RELEASING;
        key_q[i]    <= '0;
        age_q[i]    <= '0;
      end
    end else begin
      fsm_q      <= fsm_d;
      pend_key_q <= pend_key_d;
      victim_q   <= victim_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      active_q   <= active_d;
      steal_q    <= steal_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_q[i] <= vstate_d[i];
        key_q[i]    <= key_d[i];
        age_q[i]    <= age_d[i];
      end
    end
  end

  always_comb begin
    voice_key = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_key[i*KEY_W +: KEY_W] = key_q[i];
    end
  end

  assign ev_ready       = (fsm_q == S_IDLE);
  assign voice_note_on  = note_on_q;
  assign voice_note_off = note_off_q;
  assign active_mask    = active_q;
  assign steal_pulse    = steal_q;
  assign dbg_state_o    = fsm_q;

endmodule
